// File: rtl/twiddle_sequencer.sv
// Steps through every (stage, butterfly) pair of a radix-2 DIT FFT and presents
// the matching twiddle factor W_N^k from an elaboration-time table, with a valid/ready handshake.
module twiddle_sequencer #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 12,
  parameter int FRAC_W   = 10
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  input  logic                                    i_inverse,
  input  logic                                    i_out_ready,
  output logic                                    o_out_valid,
  output logic [DATA_W-1:0]                       o_w_real,
  output logic [DATA_W-1:0]                       o_w_img,
  output logic [$clog2($clog2(N_POINTS))-1:0]     o_stage,
  output logic [$clog2(N_POINTS)-2:0]             o_bfly,
  output logic [$clog2(N_POINTS)-2:0]             o_tw_index,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int S    = $clog2(N_POINTS);
  localparam int SW   = $clog2(S);
  localparam int BW   = S - 1;
  localparam int HALF = N_POINTS / 2;

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = real'(1 << FRAC_W);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic int round_away(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  logic [DATA_W-1:0] w_tbl_re [HALF];
  logic [DATA_W-1:0] w_tbl_im [HALF];

  // Table holds W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for k in [0, N/2).
  for (genvar g = 0; g < HALF; g++) begin : g_tbl
    localparam real ANG = 2.0 * PI * real'(g) / real'(N_POINTS);
    assign w_tbl_re[g] = DATA_W'(round_away($cos(ANG) * SCALE));
    assign w_tbl_im[g] = DATA_W'(round_away(-$sin(ANG) * SCALE));
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_stage;
  logic [SW-1:0]     w_stage_nxt;
  logic [BW-1:0]     r_bfly;
  logic [BW-1:0]     w_bfly_nxt;
  logic              r_inv;
  logic              w_inv_nxt;
  logic [BW-1:0]     r_tw_index;
  logic [BW-1:0]     w_k_nxt;
  logic [DATA_W-1:0] r_w_re;
  logic [DATA_W-1:0] r_w_im;
  logic [DATA_W-1:0] w_im_sel;
  logic              w_last;

  assign w_last = (r_stage == SW'(S - 1)) && (r_bfly == BW'(HALF - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_bfly_nxt  = r_bfly;
    w_inv_nxt   = r_inv;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_stage_nxt = '0;
          w_bfly_nxt  = '0;
          w_inv_nxt   = i_inverse;
        end
      end
      RUN: begin
        if (i_out_ready) begin
          if (w_last) begin
            w_state_nxt = FIN;
            w_stage_nxt = '0;
            w_bfly_nxt  = '0;
          end else if (r_bfly == BW'(HALF - 1)) begin
            w_bfly_nxt  = '0;
            w_stage_nxt = r_stage + SW'(1);
          end else begin
            w_bfly_nxt  = r_bfly + BW'(1);
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      RUN: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
      end
      FIN: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Twiddle is looked up from the *next* (s, b) so it lands on the same edge as the indices.
  assign w_k_nxt  = BW'((int'(w_bfly_nxt) & ((1 << w_stage_nxt) - 1)) << (S - 1 - int'(w_stage_nxt)));
  assign w_im_sel = w_inv_nxt ? (DATA_W'(0) - w_tbl_im[w_k_nxt]) : w_tbl_im[w_k_nxt];

  // NOTE: only control/output registers are reset; the twiddle table is constant logic, not storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage    <= '0;
      r_bfly     <= '0;
      r_inv      <= 1'b0;
      r_tw_index <= '0;
      r_w_re     <= DATA_W'(1 << FRAC_W);
      r_w_im     <= '0;
    end else begin
      r_stage    <= w_stage_nxt;
      r_bfly     <= w_bfly_nxt;
      r_inv      <= w_inv_nxt;
      r_tw_index <= w_k_nxt;
      r_w_re     <= w_tbl_re[w_k_nxt];
      r_w_im     <= w_im_sel;
    end
  end

  assign o_stage    = r_stage;
  assign o_bfly     = r_bfly;
  assign o_tw_index = r_tw_index;
  assign o_w_real   = r_w_re;
  assign o_w_img    = r_w_im;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer: N=8 and N=16 instances, hand-computed twiddle tables.
module tb_twiddle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, inverse, ready;
  logic        valid, busy, done;
  logic [11:0] wre, wim;
  logic [1:0]  stage, bfly, tw;

  logic        start16, ready16, inverse16;
  logic        valid16, busy16, done16;
  logic [11:0] wre16, wim16;
  logic [1:0]  stage16;
  logic [2:0]  bfly16, tw16;

  int n_pass  = 0;
  int n_total = 0;

  int exp_re[4]    = '{1024, 724, 0, -724};
  int exp_im[4]    = '{0, -724, -1024, -724};
  int exp_k[12]    = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int exp_re16[8]  = '{1024, 946, 724, 392, 0, -392, -724, -946};
  int exp_im16[8]  = '{0, -392, -724, -946, -1024, -946, -724, -392};

  twiddle_sequencer #(.N_POINTS(8), .DATA_W(12), .FRAC_W(10)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_inverse(inverse), .i_out_ready(ready),
    .o_out_valid(valid), .o_w_real(wre), .o_w_img(wim), .o_stage(stage), .o_bfly(bfly),
    .o_tw_index(tw), .o_busy(busy), .o_done(done)
  );

  twiddle_sequencer #(.N_POINTS(16), .DATA_W(12), .FRAC_W(10)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_inverse(inverse16), .i_out_ready(ready16),
    .o_out_valid(valid16), .o_w_real(wre16), .o_w_img(wim16), .o_stage(stage16), .o_bfly(bfly16),
    .o_tw_index(tw16), .o_busy(busy16), .o_done(done16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {valid, stage, bfly, k, re, im} for the i-th entry of an N=8 sequence.
  function automatic logic [30:0] exp_entry(input int i, input bit inv);
    int k;
    int im;
    k  = exp_k[i];
    im = inv ? -exp_im[k] : exp_im[k];
    return {1'b1, 2'(i / 4), 2'(i % 4), 2'(k), 12'(exp_re[k]), 12'(im)};
  endfunction

  function automatic logic [30:0] got_entry();
    return {valid, stage, bfly, tw, wre, wim};
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; inverse = 1'b1; ready = 1'b1;
    tick;
    n_total++;
    if ({valid, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {valid, busy, done});
    else n_pass++;
    n_total++;
    if ({stage, bfly, tw, wre, wim} !== {6'd0, 12'd1024, 12'd0})
      $display("FAIL reset_data: got %h expected %h", {stage, bfly, tw, wre, wim}, {6'd0, 12'd1024, 12'd0});
    else n_pass++;
    rst = 1'b0; start = 1'b0; inverse = 1'b0;
    tick;
    n_total++;
    if ({valid, busy} !== 2'b00) $display("FAIL reset_start_ignored: got %b expected 00", {valid, busy});
    else n_pass++;
  endtask

  task automatic test_full_seq;
    inverse = 1'b0; ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_total++;
      if (got_entry() !== exp_entry(i, 1'b0))
        $display("FAIL full_entry[%0d]: got %h expected %h", i, got_entry(), exp_entry(i, 1'b0));
      else n_pass++;
      tick;
    end
    n_total++;
    if ({valid, busy, done} !== 3'b011) $display("FAIL full_fin: got %b expected 011", {valid, busy, done});
    else n_pass++;
    tick;
    n_total++;
    if ({valid, busy, done} !== 3'b000) $display("FAIL full_idle: got %b expected 000", {valid, busy, done});
    else n_pass++;
  endtask

  task automatic test_stall;
    inverse = 1'b0; ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_total++;
      if (got_entry() !== exp_entry(i, 1'b0))
        $display("FAIL stall_entry[%0d]: got %h expected %h", i, got_entry(), exp_entry(i, 1'b0));
      else n_pass++;
      if (i == 9) begin
        ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          tick;
          n_total++;
          if ({valid, stage, bfly, tw, wre, wim} !== {1'b1, 2'd2, 2'd1, 2'd1, 12'd724, -12'sd724})
            $display("FAIL stall_hold[%0d]: got %h expected %h", h, got_entry(),
                     {1'b1, 2'd2, 2'd1, 2'd1, 12'd724, -12'sd724});
          else n_pass++;
        end
        ready = 1'b1;
      end
      tick;
    end
    n_total++;
    if ({valid, busy, done} !== 3'b011) $display("FAIL stall_fin: got %b expected 011", {valid, busy, done});
    else n_pass++;
    tick;
  endtask

  task automatic test_inverse;
    inverse = 1'b1; ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; inverse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_total++;
      if (got_entry() !== exp_entry(i, 1'b1))
        $display("FAIL inv_entry[%0d]: got %h expected %h", i, got_entry(), exp_entry(i, 1'b1));
      else n_pass++;
      tick;
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL inv_done: got %b expected 1", done);
    else n_pass++;
    tick;
  endtask

  task automatic test_start_ignored;
    int n_x;
    int n_done;
    n_x = 0; n_done = 0;
    inverse = 1'b0; ready = 1'b1; start = 1'b1;
    tick;
    for (int c = 0; c < 30; c++) begin
      start = 1'b0;
      if (done) begin
        n_done++;
        start = 1'b1;
      end
      if (valid) begin
        if (n_x < 12) begin
          n_total++;
          if (got_entry() !== exp_entry(n_x, 1'b0))
            $display("FAIL start_ign_entry[%0d]: got %h expected %h", n_x, got_entry(), exp_entry(n_x, 1'b0));
          else n_pass++;
        end
        if (n_x == 5) start = 1'b1;
        n_x++;
      end
      tick;
    end
    start = 1'b0;
    n_total++;
    if (n_x !== 12) $display("FAIL start_ign_count: got %0d expected 12", n_x);
    else n_pass++;
    n_total++;
    if (n_done !== 1) $display("FAIL start_ign_done: got %0d expected 1", n_done);
    else n_pass++;
    n_total++;
    if ({valid, busy, done} !== 3'b000) $display("FAIL start_ign_idle: got %b expected 000", {valid, busy, done});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    inverse = 1'b1; ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; inverse = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    n_total++;
    if (got_entry() !== exp_entry(7, 1'b1))
      $display("FAIL rstmid_pre: got %h expected %h", got_entry(), exp_entry(7, 1'b1));
    else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_total++;
    if ({valid, busy, done, stage, bfly, tw, wre, wim} !== {3'b000, 6'd0, 12'd1024, 12'd0})
      $display("FAIL rstmid_state: got %h expected %h", {valid, busy, done, stage, bfly, tw, wre, wim},
               {3'b000, 6'd0, 12'd1024, 12'd0});
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL rstmid_no_done[%0d]: got %b expected 00", c, {busy, done});
      else n_pass++;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_total++;
      if (got_entry() !== exp_entry(i, 1'b0))
        $display("FAIL rstmid_fresh[%0d]: got %h expected %h", i, got_entry(), exp_entry(i, 1'b0));
      else n_pass++;
      tick;
    end
    n_total++;
    if ({valid, busy, done} !== 3'b011) $display("FAIL rstmid_fin: got %b expected 011", {valid, busy, done});
    else n_pass++;
    tick;
  endtask

  task automatic test_n16;
    int n_x;
    int n_done;
    int n_k5;
    int s;
    int b;
    int k;
    logic [31:0] exp16;
    n_x = 0; n_done = 0; n_k5 = 0;
    ready16 = 1'b1; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (done16) n_done++;
      if (valid16) begin
        s = n_x / 8;
        b = n_x % 8;
        k = (b & ((1 << s) - 1)) << (3 - s);
        exp16 = {2'(s), 3'(b), 3'(k), 12'(exp_re16[k]), 12'(exp_im16[k])};
        n_total++;
        if ({stage16, bfly16, tw16, wre16, wim16} !== exp16)
          $display("FAIL n16_entry[%0d]: got %h expected %h", n_x, {stage16, bfly16, tw16, wre16, wim16}, exp16);
        else n_pass++;
        if (tw16 == 3'd5) begin
          n_k5++;
          n_total++;
          if ({wre16, wim16} !== {-12'sd392, -12'sd946})
            $display("FAIL n16_k5: got %h expected %h", {wre16, wim16}, {-12'sd392, -12'sd946});
          else n_pass++;
        end
        n_x++;
      end
      tick;
    end
    n_total++;
    if (n_x !== 32) $display("FAIL n16_count: got %0d expected 32", n_x);
    else n_pass++;
    n_total++;
    if (n_done !== 1) $display("FAIL n16_done: got %0d expected 1", n_done);
    else n_pass++;
    n_total++;
    if (n_k5 !== 1) $display("FAIL n16_k5_seen: got %0d expected 1", n_k5);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0; ready = 1'b0;
    start16 = 1'b0; ready16 = 1'b0; inverse16 = 1'b0;
    test_reset;
    test_full_seq;
    test_stall;
    test_inverse;
    test_start_ignored;
    test_reset_mid;
    test_n16;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/twiddle_sequencer.md
TWIDDLE_SEQUENCER -- requirements
Module: twiddle_sequencer

Interface
REQ-001 SHALL have parameter N_POINTS, default 8: FFT size; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter DATA_W, default 12: signed twiddle component width.
REQ-003 SHALL have parameter FRAC_W, default 10: fraction bits; DATA_W >= FRAC_W+2.
REQ-004 SHALL use one clock and a synchronous, active-high reset: CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Start  input  1  one-cycle request to begin a full twiddle sequence.
REQ-007 Inverse  input  1  sampled with Start; 1 = conjugated (IFFT) twiddles.
REQ-008 Out_Ready  input  1  downstream butterfly accepts current output.
REQ-009 Out_Valid  output  1  current output entry valid.
REQ-010 W_Real  output  DATA_W  signed twiddle real part.
REQ-011 W_Img  output  DATA_W  signed twiddle imaginary part.
REQ-012 Stage  output  clog2(clog2(N_POINTS))  current stage index s.
REQ-013 Bfly  output  clog2(N_POINTS)-1  current butterfly index b.
REQ-014 Tw_Index  output  clog2(N_POINTS)-1  twiddle exponent k.
REQ-015 Busy  output  1  high while a sequence is in progress.
REQ-016 Done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-017 SHALL hold an N_POINTS/2-entry table built at elaboration: Real[k] = round(cos(2*pi*k/N)*2^FRAC_W), Img[k] = round(-sin(2*pi*k/N)*2^FRAC_W), rounding half away from zero.
REQ-018 For N_POINTS=8 the table SHALL be Real = {1024, 724, 0, -724} and Img = {0, -724, -1024, -724}.
REQ-019 SHALL implement an FSM with states IDLE, RUN, FIN.
REQ-020 IDLE: Busy=0 and Out_Valid=0; on Start=1, latch Inverse, set s=0 and b=0, and enter RUN on the next edge.
REQ-021 RUN: Out_Valid=1 and Busy=1; outputs present the entry for (s, b) from the first RUN cycle onward.
REQ-022 SHALL compute k = (b mod 2^s) << (S-1-s), where S = log2(N_POINTS).
REQ-023 W_Real and W_Img SHALL be registered: they update on the same edge as Stage, Bfly and Tw_Index, and never lag them.
REQ-024 When Inverse is latched as 1, W_Img SHALL be the negated table value; W_Real SHALL be unchanged.
REQ-025 A transfer SHALL occur when Out_Valid=1 and Out_Ready=1 on a rising edge.
REQ-026 On each transfer, b SHALL increment; at b = N/2-1, b SHALL wrap to 0 and s SHALL increment.
REQ-027 When Out_Ready=0, all outputs SHALL hold stable and Out_Valid SHALL stay 1.
REQ-028 On transfer of the last entry (s=S-1, b=N/2-1), the FSM SHALL enter FIN; Out_Valid SHALL drop on that edge.
REQ-029 FIN SHALL last one cycle with Done=1 and Busy=1, then return to IDLE.
REQ-030 Start SHALL be ignored in RUN and FIN; the sequence in progress is unaffected.
REQ-031 Start in the same cycle that FIN is exited SHALL be ignored; a new Start is accepted from IDLE only.
REQ-032 A complete sequence SHALL comprise exactly S*N/2 transfers.

Reset
REQ-033 On RST=1 at a rising edge, the FSM SHALL enter IDLE, s=0, b=0, latched Inverse=0, and Out_Valid=Busy=Done=0.
REQ-034 On reset, W_Real SHALL be 2^FRAC_W, W_Img=0, and Stage=Bfly=Tw_Index=0.
REQ-035 RST SHALL take priority over Start and Out_Ready in the same cycle; reset mid-sequence SHALL abort it without a Done pulse.

Verification
REQ-036 N=8, Inverse=0, Out_Ready held 1, Start pulse -> 12 transfers on consecutive cycles; k sequence 0,0,0,0, 0,2,0,2, 0,1,2,3; Done on the cycle after the 12th transfer.
REQ-037 N=8, Out_Ready=0 for 3 cycles at s=2, b=1 -> W_Real=724, W_Img=-724, Tw_Index=1 held for all 3 cycles; the sequence then resumes at b=2 (0, -1024).
REQ-038 N=8, Inverse=1 -> k=3 entry gives W_Real=-724, W_Img=+724; k=2 entry gives W_Img=+1024.
REQ-039 N=16, k=5 entry -> W_Real=-392, W_Img=-946; the sequence has 32 transfers total.
REQ-040 Start pulsed during RUN at transfer 5 -> no restart; the total count stays 12 with a single Done.
REQ-041 RST asserted at transfer 7 of N=8 -> next cycle Out_Valid=0, Busy=0, no Done; a following Start yields a fresh 12-transfer sequence from s=0, b=0.
